pim_mem_arbiter: RTL and testbench

Shares the single process-in-memory array port between NREQ requesters, such as the instruction control unit and a host load/store port. It accepts one read or write request at a time and picks among requesters by round-robin. It drives the memory read/write strobes and completes each transaction on the memory's mem_ready rising edge, or on a timeout. Each requester then gets a one-cycle response carrying read data and an error flag.

---
 rtl/pim_pkg.sv | 26 ++
 rtl/pim_rr_pick.sv | 36 +++
 rtl/pim_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_pim_mem_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared definitions for the PIM memory arbiter and the instruction control unit:
// default bus widths, the arbiter state encoding and the instruction field map.
package pim_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Instruction word layout used by the control unit
  localparam int INSTR_ALU_BIT = 44;
  localparam int INSTR_OP_HI   = 43;
  localparam int INSTR_OP_LO   = 42;
  localparam int INSTR_A_HI    = 41;
  localparam int INSTR_A_LO    = 32;
  localparam int INSTR_B_HI    = 31;
  localparam int INSTR_B_LO    = 22;
  localparam int INSTR_C_HI    = 21;
  localparam int INSTR_C_LO    = 12;

endpackage

// File: rtl/pim_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module pim_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic found_s;
  int   idx_s;

  // Scan upward from ptr; the first hit wins
  always_comb begin
    found_s   = 1'b0;
    idx_s     = 0;
    grant_idx = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr) + k) % NREQ;
      if (!found_s && req[idx_s]) begin
        found_s   = 1'b1;
        grant_idx = IW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      grant = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/pim_mem_arbiter.sv
// Round-robin arbiter sharing the single PIM array port between NREQ requesters,
// one transaction at a time, with mem_ready edge completion and timeout abort.
module pim_mem_arbiter
  import pim_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STROBE_CYC = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out,
  input  logic                     mem_ready,
  output logic                     busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e        state_r, state_nxt_s;
  logic [IW-1:0]     rr_ptr_r, owner_r, grant_idx_s;
  logic [NREQ-1:0]   grant_s, rsp_valid_r;
  logic              any_s, wr_r, wr_nxt_s, rise_s, done_s, timeout_s;
  logic [2:0]        strobe_cnt_r;
  logic [TW-1:0]     wait_cnt_r;
  logic              mr_q_r, mem_read_r, mem_write_r, rsp_err_r, busy_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_data_in_r, rsp_rdata_r;

  pim_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign any_s     = |grant_s;
  assign rise_s    = mem_ready & ~mr_q_r;
  assign done_s    = rise_s && ((state_r == ISSUE) || (state_r == WAIT));
  assign timeout_s = (wait_cnt_r == TW'(TIMEOUT - 1));

  // Accept pulse is only offered from IDLE and is held off while in reset
  assign req_ready   = ((state_r == IDLE) && !rst) ? grant_s : {NREQ{1'b0}};
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign mem_address = mem_address_r;
  assign mem_data_in = mem_data_in_r;
  assign busy        = busy_r;

  // Next-state and next-direction decode
  always_comb begin
    state_nxt_s = state_r;
    wr_nxt_s    = wr_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nxt_s = ISSUE;
          wr_nxt_s    = req_write[grant_idx_s];
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (rise_s || timeout_s) begin
          state_nxt_s = RESP;
        end else if (strobe_cnt_r == 3'(STROBE_CYC - 1)) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        if (rise_s || timeout_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, counters, captured request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= {IW{1'b0}};
      owner_r       <= {IW{1'b0}};
      wr_r          <= 1'b0;
      strobe_cnt_r  <= 3'd0;
      wait_cnt_r    <= {TW{1'b0}};
      mr_q_r        <= 1'b0;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_address_r <= {ADDR_W{1'b0}};
      mem_data_in_r <= {DATA_W{1'b0}};
      rsp_valid_r   <= {NREQ{1'b0}};
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wr_r         <= wr_nxt_s;
      mr_q_r       <= mem_ready;
      busy_r       <= (state_nxt_s != IDLE);
      mem_read_r   <= (state_nxt_s == ISSUE) && !wr_nxt_s;
      mem_write_r  <= (state_nxt_s == ISSUE) && wr_nxt_s;
      strobe_cnt_r <= (state_r == ISSUE) ? strobe_cnt_r + 3'd1 : 3'd0;
      wait_cnt_r   <= ((state_r == ISSUE) || (state_r == WAIT)) ? wait_cnt_r + TW'(1) : {TW{1'b0}};
      if ((state_r == IDLE) && any_s) begin
        owner_r       <= grant_idx_s;
        mem_address_r <= req_addr[grant_idx_s*ADDR_W +: ADDR_W];
        mem_data_in_r <= req_wdata[grant_idx_s*DATA_W +: DATA_W];
        rr_ptr_r      <= (int'(grant_idx_s) == NREQ - 1) ? {IW{1'b0}} : grant_idx_s + IW'(1);
      end else begin
        owner_r <= owner_r;
      end
      if (state_nxt_s == RESP) begin
        rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
        rsp_err_r   <= !rise_s;
      end else begin
        rsp_valid_r <= {NREQ{1'b0}};
        rsp_err_r   <= 1'b0;
      end
      if (done_s && !wr_r) begin
        rsp_rdata_r <= mem_data_out;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_pim_mem_arbiter.sv
// Directed bench for pim_mem_arbiter: read, round-robin writes, held mem_ready,
// timeout, reset mid-transaction and early completion.
module tb_pim_mem_arbiter;

  logic        clk, rst;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mem_data_in, mem_data_out;
  logic        rsp_err, mem_read, mem_write, mem_ready, busy;
  logic [9:0]  mem_address;

  int total = 0;
  int bad   = 0;
  int n;
  logic [1:0]  exp_g;
  logic [9:0]  exp_a;
  logic [31:0] exp_d;

  pim_mem_arbiter #(
    .NREQ(2), .ADDR_W(10), .DATA_W(32), .STROBE_CYC(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(req_ready), 64'h0);
    chk({tag, "_rsp"}, 64'(rsp_valid), 64'h0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'h0);
    chk({tag, "_err"}, 64'(rsp_err), 64'h0);
    chk({tag, "_strb"}, 64'({mem_read, mem_write}), 64'h0);
    chk({tag, "_addr"}, 64'(mem_address), 64'h0);
    chk({tag, "_wd"}, 64'(mem_data_in), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = 20'h0;
    req_wdata = 64'h0; mem_data_out = 32'h0; mem_ready = 1'b0;
    tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single read from requester 0, mem_ready rising in the first WAIT cycle
    req_valid = 2'b01; req_write = 2'b00; req_addr = {10'h000, 10'h005};
    #1 chk("rd_ready", 64'(req_ready), 64'h1);
    tick(); req_valid = 2'b00;
    chk("rd_strobe1", 64'({mem_read, mem_write}), 64'h2);
    chk("rd_addr", 64'(mem_address), 64'h005);
    chk("rd_busy", 64'(busy), 64'h1);
    tick(); chk("rd_strobe2", 64'({mem_read, mem_write}), 64'h2);
    tick(); chk("rd_strobe_off", 64'({mem_read, mem_write}), 64'h0);
    tick(); mem_ready = 1'b1; mem_data_out = 32'hDEADBEEF;
    chk("rd_no_rsp_yet", 64'(rsp_valid), 64'h0);
    tick(); mem_ready = 1'b0;
    chk("rd_rsp", 64'(rsp_valid), 64'h1);
    chk("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("rd_err", 64'(rsp_err), 64'h0);
    tick();
    chk("rd_rsp_pulse", 64'(rsp_valid), 64'h0);
    chk("rd_idle", 64'(busy), 64'h0);
    chk("rd_hold", 64'(rsp_rdata), 64'hDEADBEEF);

    // Reset pulse so the pointer starts at requester 0
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Both requesters keep writing: grants alternate 0,1,0,1
    req_valid = 2'b11; req_write = 2'b11; req_addr = {10'h020, 10'h010};
    req_wdata = {32'h22222222, 32'h11111111};
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 10'h010 : 10'h020;
      exp_d = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
      chk("rr_ready", 64'(req_ready), 64'(exp_g));
      chk("rr_idle_wr", 64'(mem_write), 64'h0);
      tick();
      chk("rr_write", 64'({mem_read, mem_write}), 64'h1);
      chk("rr_addr", 64'(mem_address), 64'(exp_a));
      chk("rr_wdata", 64'(mem_data_in), 64'(exp_d));
      tick(); mem_ready = 1'b1;
      tick(); mem_ready = 1'b0;
      chk("rr_rsp", 64'(rsp_valid), 64'(exp_g));
      chk("rr_resp_strobe", 64'({mem_read, mem_write, req_ready}), 64'h0);
      tick();
    end
    req_valid = 2'b00;

    // mem_ready already high at issue must fall and rise again
    mem_ready = 1'b1; mem_data_out = 32'h12345678;
    req_valid = 2'b01; req_write = 2'b00; req_addr = {10'h000, 10'h033};
    tick(); req_valid = 2'b00;
    chk("hi_addr", 64'(mem_address), 64'h033);
    tick(); chk("hi_no_rsp1", 64'(rsp_valid), 64'h0);
    tick(); chk("hi_no_rsp2", 64'(rsp_valid), 64'h0);
    chk("hi_busy", 64'(busy), 64'h1);
    mem_ready = 1'b0;
    tick(); chk("hi_no_rsp3", 64'(rsp_valid), 64'h0);
    mem_ready = 1'b1; mem_data_out = 32'hCAFEF00D;
    tick(); mem_ready = 1'b0;
    chk("hi_rsp", 64'(rsp_valid), 64'h1);
    chk("hi_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    tick();

    // Timeout: requester 1 read with no mem_ready edge
    req_valid = 2'b10; req_write = 2'b00; req_addr = {10'h044, 10'h000};
    #1 chk("to_ready", 64'(req_ready), 64'h2);
    tick(); req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", 64'(n), 64'd64);
    chk("to_rsp", 64'(rsp_valid), 64'h2);
    chk("to_err", 64'(rsp_err), 64'h1);
    chk("to_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    tick();
    chk("to_done", 64'({rsp_valid, rsp_err, busy}), 64'h0);

    // Reset while waiting abandons the write; requester 1 then wins at once
    req_valid = 2'b01; req_write = 2'b01; req_addr = {10'h000, 10'h055};
    req_wdata = {32'h0, 32'hA5A5A5A5};
    tick(); req_valid = 2'b00;
    tick(); tick();
    chk("rw_wait_busy", 64'({busy, mem_write}), 64'h2);
    rst = 1'b1; req_valid = 2'b10; req_write = 2'b00; req_addr = {10'h077, 10'h000};
    #1 chk_idle_outputs("rw_async");
    tick(); rst = 1'b0;
    #1 chk("rw_no_rsp", 64'(rsp_valid), 64'h0);
    chk("rw_ready1", 64'(req_ready), 64'h2);

    // Early completion: mem_ready rises in the first ISSUE cycle
    tick(); req_valid = 2'b00;
    chk("ec_read", 64'({mem_read, mem_write}), 64'h2);
    chk("ec_addr", 64'(mem_address), 64'h077);
    mem_ready = 1'b1; mem_data_out = 32'h0BADCAFE;
    tick(); mem_ready = 1'b0;
    chk("ec_rsp", 64'(rsp_valid), 64'h2);
    chk("ec_strobe_drop", 64'({mem_read, mem_write}), 64'h0);
    chk("ec_rdata", 64'(rsp_rdata), 64'h0BADCAFE);
    tick();
    chk("ec_idle", 64'({busy, rsp_valid}), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
